// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the 8-to-3 queued priority encoder.
// prio_enc8 returns 0 for an all-zero vector; callers qualify it with a separate valid.
package prio_enc_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_vec_t onehot8(idx_t idx);
    req_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic idx_t prio_enc8(req_vec_t vec, logic hi_msb);
    idx_t idx;
    idx = '0;
    if (hi_msb) begin
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (vec[i]) idx = i[IDX_W-1:0];
      end
    end else begin
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
        if (vec[i]) idx = i[IDX_W-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/edge_capture8.sv
// Registers the request lines and produces per-bit capture strobes.
// In edge mode a strobe is a rising edge; in level mode it is the raw line.
module edge_capture8
  import prio_enc_pkg::*;
#(
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t d_i,
  output req_vec_t rise_o
);

  req_vec_t d_q;

  // Sampled unconditionally so that re-enabling capture never sees a stale history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
    end else begin
      d_q <= d_i;
    end
  end

  always_comb begin
    rise_o = EDGE_DETECT ? (d_i & ~d_q) : d_i;
  end

endmodule

// File: rtl/prio_encoder_8to3_q.sv
// Registered 8-to-3 priority encoder with request queueing.
// Captured events wait in pend; the presented index holds until acked (no preemption).
module prio_encoder_8to3_q
  import prio_enc_pkg::*;
#(
  parameter bit EDGE_DETECT = 1'b1,
  parameter bit HI_PRIO_MSB = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e,
  input  logic [N_REQ-1:0] d,
  input  logic             ack,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic [N_REQ-1:0] pend,
  output logic             ovf
);

  req_vec_t rise;
  req_vec_t set;
  req_vec_t clr;
  req_vec_t pend_q, pend_d;
  idx_t     y_q, y_d;
  logic     valid_q, valid_d;
  logic     ovf_q, ovf_d;

  edge_capture8 #(
    .EDGE_DETECT(EDGE_DETECT)
  ) u_edge_capture8 (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (d),
    .rise_o(rise)
  );

  always_comb begin
    set     = rise & {N_REQ{e}};
    clr     = (valid_q && ack) ? onehot8(y_q) : '0;
    // A same-cycle set beats the clear, so the bit survives its own ack.
    pend_d  = (pend_q & ~clr) | set;
    ovf_d   = ovf_q | (|(set & pend_q & ~clr));
    y_d     = y_q;
    valid_d = valid_q;
    if (!(valid_q && !ack)) begin
      valid_d = |pend_d;
      y_d     = prio_enc8(pend_d, HI_PRIO_MSB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pend  = pend_q;
  assign y     = y_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_prio_encoder_8to3_q.sv
// Bench for prio_encoder_8to3_q: three parameterisations share one stimulus stream,
// checked against directed tables and a queue-level reference model.
module tb_prio_encoder_8to3_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e_r;
  logic [7:0] d_r;
  logic       ack_r;

  // 0: edge, MSB-high   1: edge, LSB-high   2: level, MSB-high
  logic [2:0] y_w[3];
  logic       valid_w[3];
  logic [7:0] pend_w[3];
  logic       ovf_w[3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prio_encoder_8to3_q #(.EDGE_DETECT(1'b1), .HI_PRIO_MSB(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .e(e_r), .d(d_r), .ack(ack_r),
    .y(y_w[0]), .valid(valid_w[0]), .pend(pend_w[0]), .ovf(ovf_w[0])
  );
  prio_encoder_8to3_q #(.EDGE_DETECT(1'b1), .HI_PRIO_MSB(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .e(e_r), .d(d_r), .ack(ack_r),
    .y(y_w[1]), .valid(valid_w[1]), .pend(pend_w[1]), .ovf(ovf_w[1])
  );
  prio_encoder_8to3_q #(.EDGE_DETECT(1'b0), .HI_PRIO_MSB(1'b1)) u_lvl (
    .clk(clk), .rst_n(rst_n), .e(e_r), .d(d_r), .ack(ack_r),
    .y(y_w[2]), .valid(valid_w[2]), .pend(pend_w[2]), .ovf(ovf_w[2])
  );

  // Reference model: a set of waiting request numbers plus the one being presented.
  bit         m_pend[3][8];
  int         m_y[3];
  bit         m_valid[3];
  bit         m_ovf[3];
  logic [7:0] m_dq;

  function automatic bit edge_of(int k);
    return k != 2;
  endfunction

  function automatic bit hi_of(int k);
    return k != 1;
  endfunction

  function automatic int pick(logic [7:0] v, bit hi);
    if (hi) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pack(int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[k][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) m_pend[k][i] = 1'b0;
      m_y[k] = 0;
      m_valid[k] = 1'b0;
      m_ovf[k] = 1'b0;
    end
    m_dq = 8'h00;
  endtask

  task automatic model_update();
    int         c;
    int         p;
    bit         r;
    bit         s;
    logic [7:0] nxt;
    for (int k = 0; k < 3; k++) begin
      c = (m_valid[k] && ack_r) ? m_y[k] : -1;
      for (int i = 0; i < 8; i++) begin
        r = edge_of(k) ? (d_r[i] && !m_dq[i]) : d_r[i];
        s = r && e_r;
        if (s && m_pend[k][i] && i != c) m_ovf[k] = 1'b1;
        nxt[i] = (m_pend[k][i] && i != c) || s;
      end
      for (int i = 0; i < 8; i++) m_pend[k][i] = nxt[i];
      if (!(m_valid[k] && !ack_r)) begin
        p = pick(nxt, hi_of(k));
        m_valid[k] = (p >= 0);
        m_y[k] = (p >= 0) ? p : 0;
      end
    end
    m_dq = d_r;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec(int k);
    return {19'd0, pend_w[k], y_w[k], valid_w[k], ovf_w[k]};
  endfunction

  function automatic logic [31:0] mdl_vec(int k);
    logic [2:0] yy;
    yy = 3'(m_y[k]);
    return {19'd0, pack(k), yy, m_valid[k], m_ovf[k]};
  endfunction

  task automatic chk_model();
    for (int k = 0; k < 3; k++) chk($sformatf("model_inst%0d", k), dut_vec(k), mdl_vec(k));
  endtask

  // One clock: advance model alongside the DUTs, then sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    d_r = 8'h00;
    ack_r = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_inst%0d", k), dut_vec(k), 32'd0);
    rst_n = 1'b1;
  endtask

  // Asynchronous reset check: outputs must clear well before the next edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("async_rst_inst%0d", k), dut_vec(k), 32'd0);
    do_reset();
  endtask

  typedef struct packed {
    bit         rst;
    bit         e;
    logic [7:0] d;
    bit         ack;
    logic [7:0] pend;
    logic [2:0] y;
    bit         valid;
    bit         ovf;
  } row_t;

  row_t tbl[29];

  function automatic row_t mk(bit rst, bit e, logic [7:0] d, bit ack, logic [7:0] pend,
                              logic [2:0] y, bit valid, bit ovf);
    row_t r;
    r.rst = rst; r.e = e; r.d = d; r.ack = ack;
    r.pend = pend; r.y = y; r.valid = valid; r.ovf = ovf;
    return r;
  endfunction

  initial begin
    tbl[0]  = mk(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    tbl[1]  = mk(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    tbl[2]  = mk(0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    tbl[3]  = mk(0, 1, 8'h20, 1, 8'h00, 3'd0, 0, 0);
    tbl[4]  = mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    tbl[5]  = mk(0, 1, 8'h05, 0, 8'h05, 3'd2, 1, 0);
    tbl[6]  = mk(0, 1, 8'h85, 0, 8'h85, 3'd2, 1, 0);
    tbl[7]  = mk(0, 1, 8'h85, 1, 8'h81, 3'd7, 1, 0);
    tbl[8]  = mk(0, 1, 8'h85, 1, 8'h01, 3'd0, 1, 0);
    tbl[9]  = mk(0, 1, 8'h85, 1, 8'h00, 3'd0, 0, 0);
    tbl[10] = mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    tbl[11] = mk(0, 1, 8'h85, 0, 8'h85, 3'd7, 1, 0);
    tbl[12] = mk(0, 1, 8'h85, 1, 8'h05, 3'd2, 1, 0);
    tbl[13] = mk(0, 1, 8'h85, 1, 8'h01, 3'd0, 1, 0);
    tbl[14] = mk(0, 1, 8'h85, 1, 8'h00, 3'd0, 0, 0);
    tbl[15] = mk(0, 0, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    tbl[16] = mk(0, 1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    tbl[17] = mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    tbl[18] = mk(0, 1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    tbl[19] = mk(0, 1, 8'h08, 1, 8'h00, 3'd0, 0, 0);
    tbl[20] = mk(0, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    tbl[21] = mk(0, 1, 8'h00, 0, 8'h10, 3'd4, 1, 0);
    tbl[22] = mk(0, 1, 8'h10, 0, 8'h10, 3'd4, 1, 1);
    tbl[23] = mk(0, 1, 8'h00, 0, 8'h10, 3'd4, 1, 1);
    tbl[24] = mk(1, 1, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    tbl[25] = mk(0, 1, 8'h00, 0, 8'h10, 3'd4, 1, 0);
    tbl[26] = mk(0, 1, 8'h10, 1, 8'h10, 3'd4, 1, 0);
    tbl[27] = mk(0, 1, 8'h00, 1, 8'h00, 3'd0, 0, 0);
    tbl[28] = mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);

    rst_n = 1'b0;
    e_r = 1'b1;
    d_r = 8'h00;
    ack_r = 1'b0;
    @(negedge clk);
    do_reset();
    step();
    chk("idle_msb", dut_vec(0), 32'd0);

    // Directed sequence on the edge-triggered, MSB-priority instance.
    for (int i = 0; i < 29; i++) begin
      if (tbl[i].rst) mid_reset();
      e_r = tbl[i].e;
      d_r = tbl[i].d;
      ack_r = tbl[i].ack;
      step();
      chk($sformatf("row%0d", i), dut_vec(0),
          {19'd0, tbl[i].pend, tbl[i].y, tbl[i].valid, tbl[i].ovf});
    end

    // Level mode: a held line is re-presented every cycle despite ack, without overflow.
    do_reset();
    e_r = 1'b1;
    d_r = 8'h02;
    ack_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("level_hold%0d", i), dut_vec(2), {19'd0, 8'h02, 3'd1, 1'b1, 1'b0});
    end
    d_r = 8'h00;
    step();
    chk("level_drop", dut_vec(2), 32'd0);

    // Randomised traffic against the reference model, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 299) == 0) mid_reset();
      e_r = ($urandom_range(0, 7) != 0);
      d_r = 8'($urandom & $urandom);
      ack_r = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
